// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the RV32I load/store funct3 codes, the arbiter FSM encoding, the
// last-served marker used for round-robin, the access-size decode helper and
// the NOP instruction returned when a fetch times out.
package mem_port_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } state_e;

  typedef enum logic {
    SRV_IF = 1'b0,
    SRV_D  = 1'b1
  } served_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Undefined funct3 codes fall through to a plain word access.
  function automatic size_e access_size(input logic we, input logic [2:0] funct3);
    size_e sz;
    sz = SZ_WORD;
    if (we) begin
      if (funct3 == F3_SB)      sz = SZ_BYTE;
      else if (funct3 == F3_SH) sz = SZ_HALF;
    end else begin
      if ((funct3 == F3_LB) || (funct3 == F3_LBU))      sz = SZ_BYTE;
      else if ((funct3 == F3_LH) || (funct3 == F3_LHU)) sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_steer.sv
// Combinational byte-lane logic for RV32I loads and stores.
// Ports:
//   we, funct3, addr_lo  : access type and byte offset within the word
//   wdata                : right-aligned store data
//   rdata                : raw memory word for a load
//   be, wdata_lane       : byte enables and replicated store data
//   rdata_ext            : selected and sign/zero-extended load data
//   misaligned           : half access on odd address or word access off a word boundary
module mem_port_arbiter_lane_steer
  import mem_port_arbiter_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  size_e       sz;
  logic        sext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign sz      = access_size(we, funct3);
  assign sext    = ~we & ((funct3 == F3_LB) | (funct3 == F3_LH));
  assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
  end

  always_comb begin
    be         = 4'hF;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (sz)
      SZ_BYTE: begin
        if (we) begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        rdata_ext = {{24{sext & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        if (we) begin
          be         = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        rdata_ext = {{16{sext & rd_half[15]}}, rd_half};
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and the
// load/store path, with round-robin on contention and a per-transfer timeout.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt       : fetch request handshake
//   if_valid/if_rdata           : fetch completion pulse and instruction
//   d_req/d_we/d_funct3/d_addr/d_wdata/d_gnt : load/store request handshake
//   d_valid/d_rdata/d_err       : load/store completion, extended data, error pulse
//   m_req/m_we/m_addr/m_be/m_wdata/m_rdata/m_ack : memory macro interface
//   stall                       : a requester is still waiting for its result
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall
);

  state_e            state_q, state_d;
  served_e           last_q, last_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic              busy;
  logic              ls_we;
  logic [2:0]        ls_f3;
  logic [1:0]        ls_lo;
  logic [3:0]        ls_be;
  logic [31:0]       ls_wdata;
  logic [31:0]       ls_rdata;
  logic              ls_mis;

  assign busy = (state_q != ST_IDLE);

  // One steering instance serves both directions: in IDLE it decodes the
  // incoming data request, in BUSY it extends the returning word using the
  // latched access fields.
  assign ls_we = busy ? we_q : d_we;
  assign ls_f3 = busy ? f3_q : d_funct3;
  assign ls_lo = busy ? addr_q[1:0] : d_addr[1:0];

  mem_port_arbiter_lane_steer u_lane_steer (
    .we         (ls_we),
    .funct3     (ls_f3),
    .addr_lo    (ls_lo),
    .wdata      (d_wdata),
    .rdata      (m_rdata),
    .be         (ls_be),
    .wdata_lane (ls_wdata),
    .rdata_ext  (ls_rdata),
    .misaligned (ls_mis)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    f3_d       = f3_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    if_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    d_valid_d  = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_err_d    = 1'b0;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Fetch wins when alone or when data was served last.
        if (if_req && (!d_req || (last_q == SRV_D))) begin
          if_gnt  = 1'b1;
          addr_d  = if_addr;
          we_d    = 1'b0;
          f3_d    = F3_LW;
          be_d    = 4'hF;
          wdata_d = '0;
          state_d = ST_BUSY_IF;
        end else if (d_req) begin
          d_gnt = 1'b1;
          // A misaligned access is acknowledged and rejected without touching
          // memory or the round-robin pointer.
          if (ls_mis) begin
            d_err_d = 1'b1;
          end else begin
            addr_d  = d_addr;
            we_d    = d_we;
            f3_d    = d_funct3;
            be_d    = ls_be;
            wdata_d = d_we ? ls_wdata : '0;
            state_d = ST_BUSY_D;
          end
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (m_ack || (cnt_q == TO_W'(TIMEOUT - 1))) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          // A timed-out transfer still counts as served so a dead address
          // cannot starve the other requester.
          if (state_q == ST_BUSY_IF) begin
            last_d     = SRV_IF;
            if_valid_d = 1'b1;
            if_rdata_d = m_ack ? m_rdata : NOP_INSTR;
          end else begin
            last_d = SRV_D;
            if (m_ack) begin
              d_valid_d = 1'b1;
              d_rdata_d = we_q ? '0 : ls_rdata;
            end else begin
              d_err_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= SRV_D;
      cnt_q      <= '0;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      d_valid_q  <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      d_valid_q  <= d_valid_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
    end
  end

  // Transaction fields need no reset: they only reach the memory port while busy.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    f3_q    <= f3_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  assign m_req   = busy;
  assign m_we    = (state_q == ST_BUSY_D) & we_q;
  assign m_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign m_be    = busy ? be_q : 4'h0;
  assign m_wdata = busy ? wdata_q : '0;

  assign if_valid = if_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_valid  = d_valid_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;

  assign stall = (if_req & ~if_valid_q) | (d_req & ~d_valid_q & ~d_err_q);

endmodule
